// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit instruction words into a byte-wide instruction memory, little-endian.
// Latency: a word accepted in cycle N is written as 4 bytes in cycles N+1..N+4; next acceptance at N+5 earliest.
// Backpressure: word_ready is high only while waiting for a word; the source holds word_in until accepted.
// Optional: define LOADER_CHECKSUM_EN to keep a modulo-2^32 running sum of accepted words on checksum.
module instr_mem_loader #(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [31:0]       word_in,
   input  logic              word_valid,
   input  logic              word_last,
   output logic              word_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [31:0]       checksum
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_WORD = 2'd1,
      WRITE     = 2'd2,
      DONE      = 2'd3
   } state_t;

   // Base address of the last word slot in memory; reaching it without word_last is an overflow.
   localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(MEM_BYTES - 4);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] base;
   logic [1:0]        byte_idx;
   logic [31:0]       word_q;
   logic              last_q;
   logic              session_start;
   logic              accept;
   logic              final_byte;
   logic              hit_end;

   assign hit_end  = (base == LAST_BASE);
   assign mem_addr = base + ADDR_W'(byte_idx);

   // State register; reset wins over start and over any handshake in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and Moore-style outputs, plus single-cycle control strobes for the datapath.
   always_comb begin
      state_nxt     = state;
      word_ready    = 1'b0;
      mem_we        = 1'b0;
      cpu_hold      = 1'b0;
      done          = 1'b0;
      session_start = 1'b0;
      accept        = 1'b0;
      final_byte    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               session_start = 1'b1;
               state_nxt     = WAIT_WORD;
            end
         end
         WAIT_WORD: begin
            word_ready = 1'b1;
            cpu_hold   = 1'b1;
            if (word_valid) begin
               accept    = 1'b1;
               state_nxt = WRITE;
            end
         end
         WRITE: begin
            mem_we   = 1'b1;
            cpu_hold = 1'b1;
            if (byte_idx == 2'd3) begin
               final_byte = 1'b1;
               // An exact fill with word_last set is a clean finish, not an overflow.
               if (last_q || hit_end) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = WAIT_WORD;
               end
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               session_start = 1'b1;
               state_nxt     = WAIT_WORD;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: captured word, byte counter, base address and overflow flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         base     <= '0;
         byte_idx <= 2'd0;
         word_q   <= 32'h0;
         last_q   <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (session_start) begin
            base     <= '0;
            byte_idx <= 2'd0;
            overflow <= 1'b0;
         end
         if (accept) begin
            word_q   <= word_in;
            last_q   <= word_last;
            byte_idx <= 2'd0;
         end
         if (mem_we) begin
            byte_idx <= byte_idx + 2'd1;
         end
         if (final_byte && !last_q) begin
            // Base is left unwrapped on overflow so nothing can be written past the end.
            if (hit_end) begin
               overflow <= 1'b1;
            end else begin
               base <= base + ADDR_W'(4);
            end
         end
      end
   end

   // Byte lane select for the little-endian write order.
   always_comb begin
      mem_wdata = word_q[7:0];
      case (byte_idx)
         2'd0:    mem_wdata = word_q[7:0];
         2'd1:    mem_wdata = word_q[15:8];
         2'd2:    mem_wdata = word_q[23:16];
         default: mem_wdata = word_q[31:24];
      endcase
   end

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] sum_q;

   // Running sum of accepted words, cleared at the start of each session.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_q <= 32'h0;
      end else if (session_start) begin
         sum_q <= 32'h0;
      end else if (accept) begin
         sum_q <= sum_q + word_in;
      end
   end

   assign checksum = sum_q;
`else
   assign checksum = 32'h0;
`endif

endmodule
